// File: rtl/rotor_stepping_controller.sv
// -----------------------------------------------------------------------------
// rotor_stepping_controller
//
// Stepping sequencer for a three-rotor Enigma stack. A key-press level becomes
// exactly one stepping event per press. The block holds the left, middle and
// right rotor positions (0..25) and applies the notch carry. This includes the
// middle-rotor double-step. A synchronous load of initial positions overrides
// any stepping.
//
// Ports:
//   clk         system clock (single domain)
//   reset       synchronous, active-high reset
//   key_press   key level, already synchronised to clk (1 = key down)
//   load        load init_* into the positions; wins over stepping
//   init_l/m/r  initial positions; values 26..31 load as 0..5
//   pos_l/m/r   rotor positions 0..25 (registered)
//   step_valid  one-cycle pulse: positions were just updated by a step
//   busy        high whenever the sequencer is not idle
//   at_notch_l  pos_l == NOTCH_L (decoded from the register)
// -----------------------------------------------------------------------------
module rotor_stepping_controller #(
  parameter int NOTCH_R = 21,  // right-rotor turnover (rotor III, V)
  parameter int NOTCH_M = 4,   // middle-rotor turnover (rotor II, E)
  parameter int NOTCH_L = 16   // left-rotor notch (rotor I, Q), display only
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_press,
  input  logic       load,
  input  logic [4:0] init_l,
  input  logic [4:0] init_m,
  input  logic [4:0] init_r,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic       step_valid,
  output logic       busy,
  output logic       at_notch_l
);

  localparam logic [4:0] NOTCH_R_V = 5'(NOTCH_R);
  localparam logic [4:0] NOTCH_M_V = 5'(NOTCH_M);
  localparam logic [4:0] NOTCH_L_V = 5'(NOTCH_L);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STEP     = 2'd1,
    DONE     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t state, state_next;
  logic   key_prev;
  logic   key_rise;
  logic   step_en;
  logic   step_m;
  logic   step_l;

  // Advance one position with wrap; a wrap never carries by itself.
  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // Fold out-of-range load values 26..31 onto 0..5.
  function automatic logic [4:0] reduce26(input logic [4:0] v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

  assign key_rise = key_press & ~key_prev;

  // Carry decisions use the pre-step positions. The middle rotor also steps
  // when it sits on its own notch, which produces the double-step.
  assign step_m = (pos_r == NOTCH_R_V) || (pos_m == NOTCH_M_V);
  assign step_l = (pos_m == NOTCH_M_V);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    step_en    = 1'b0;
    unique case (state)
      IDLE:     if (key_rise) state_next = STEP;
      STEP: begin
        step_en    = 1'b1;
        state_next = DONE;
      end
      DONE:     state_next = WAIT_REL;
      WAIT_REL: if (!key_press) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      // Treat the key as already down so a key held through reset cannot step.
      key_prev   <= 1'b1;
      pos_l      <= 5'd0;
      pos_m      <= 5'd0;
      pos_r      <= 5'd0;
      step_valid <= 1'b0;
    end else begin
      key_prev <= key_press;
      if (load) begin
        // A step that coincides with a load is dropped.
        state      <= IDLE;
        step_valid <= 1'b0;
        pos_l      <= reduce26(init_l);
        pos_m      <= reduce26(init_m);
        pos_r      <= reduce26(init_r);
      end else begin
        state      <= state_next;
        // Raised on leaving STEP, so it is high for exactly the DONE cycle.
        step_valid <= step_en;
        if (step_en) begin
          pos_r <= inc26(pos_r);
          if (step_m) pos_m <= inc26(pos_m);
          if (step_l) pos_l <= inc26(pos_l);
        end
      end
    end
  end

  assign busy       = (state != IDLE);
  assign at_notch_l = (pos_l == NOTCH_L_V);

endmodule
